// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add sequencer: word width,
// FSM state type and a word-select helper used for the operand muxes.
package mp_add_pkg;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 16;
    localparam int MAX_IDXW  = 4;
    localparam int MAX_W     = WORD_W * MAX_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operands are zero-padded to MAX_W so one helper serves every WORDS value.
    function automatic logic [WORD_W-1:0] word_sel(input logic [MAX_W-1:0] v,
                                                   input logic [MAX_IDXW-1:0] k);
        return v[WORD_W*int'(k) +: WORD_W];
    endfunction

endpackage

// File: rtl/adder_32.sv
// 32-bit ripple-carry adder with carry-in and carry-out.
module adder_32 (
    output logic [31:0] sum,
    output logic        cout,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        cin
);

    assign {cout, sum} = {1'b0, in1} + {1'b0, in2} + {32'b0, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder: adds two WORDS x 32-bit operands plus carry-in one word
// per cycle on a single adder_32, LS word first, carry chained through a register.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32*WORDS-1:0]     in_a,
    input  logic [32*WORDS-1:0]     in_b,
    input  logic                    in_cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [32*WORDS-1:0]     out_sum,
    output logic                    out_cout,
    output logic                    busy
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SW   = WORD_W * WORDS;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic [SW-1:0]   a_q, b_q, sum_q;
    logic            cout_q;

    logic [MAX_W-1:0]    a_pad, b_pad;
    logic [MAX_IDXW-1:0] idx_pad;
    logic [WORD_W-1:0]   add_in1, add_in2, add_sum;
    logic                add_cout;
    logic                last_word;
    logic                accept;
    logic                release_res;

    assign last_word   = (idx_q == IDXW'(WORDS - 1));
    assign accept      = in_valid && in_ready;
    assign release_res = out_valid && out_ready;

    always_comb begin
        a_pad              = '0;
        b_pad              = '0;
        idx_pad            = '0;
        a_pad[SW-1:0]      = a_q;
        b_pad[SW-1:0]      = b_q;
        idx_pad[IDXW-1:0]  = idx_q;
    end

    assign add_in1 = word_sel(a_pad, idx_pad);
    assign add_in2 = word_sel(b_pad, idx_pad);

    adder_32 u_adder (
        .sum  (add_sum),
        .cout (add_cout),
        .in1  (add_in1),
        .in2  (add_in2),
        .cin  (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = RUN;
            RUN:     if (last_word)   state_d = DONE;
            DONE:    if (release_res) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // Datapath: the only carry path between words is carry_q, so the
    // critical path never spans more than one adder_32.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[WORD_W*int'(idx_q) +: WORD_W] <= add_sum;
                    carry_q <= add_cout;
                    if (last_word) cout_q <= add_cout;
                    else           idx_q  <= idx_q + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4): directed corner cases plus
// randomized operands and stalls against a 129-bit arithmetic reference.
module tb_mp_add_seq;

    localparam int WORDS = 4;
    localparam int SW    = 32 * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_a, in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;
    logic          out_cout;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [SW:0] got, input logic [SW:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [SW:0] ref_add(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    endfunction

    function automatic logic [SW-1:0] rand_wide();
        logic [SW-1:0] v;
        for (int w = 0; w < WORDS; w++) begin
            case ($urandom_range(0, 5))
                0:       v[32*w +: 32] = 32'hFFFF_FFFF;
                1:       v[32*w +: 32] = 32'h0;
                default: v[32*w +: 32] = $urandom;
            endcase
        end
        return v;
    endfunction

    // Present one operand set; returns just after the accept edge.
    task automatic start_req(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic cin,
                             input string tag);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        check_eq({tag, ".in_ready"}, {{SW{1'b0}}, in_ready}, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic cin,
                          input int stalls, input bit inject, input string tag);
        logic [SW:0] exp;
        logic [SW:0] held;
        int          n;
        bit          seen;
        exp = ref_add(a, b, cin);
        start_req(a, b, cin, tag);
        seen = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        check_eq({tag, ".latency"}, (SW+1)'(n), (SW+1)'(WORDS + 1));
        if (!seen) return;
        held = {out_cout, out_sum};
        check_eq({tag, ".result"}, held, exp);
        check_eq({tag, ".done_flags"}, {{(SW-1){1'b0}}, in_ready, busy}, 1);
        for (int s = 0; s < stalls; s++) begin
            out_ready = 1'b0;
            if (inject && s == 1) begin
                in_a     = ~a;
                in_b     = ~b;
                in_cin   = ~cin;
                in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check_eq({tag, ".stall_hold"}, {out_cout, out_sum}, exp);
            check_eq({tag, ".stall_flags"}, {{(SW-1){1'b0}}, out_valid, in_ready}, 2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        check_eq({tag, ".after_hs"}, {{(SW-1){1'b0}}, out_valid, in_ready}, 1);
        if (inject) begin
            seen = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (out_valid || busy) seen = 1'b1;
            end
            check_eq({tag, ".no_spurious"}, {{SW{1'b0}}, seen}, 0);
        end
    endtask

    initial begin
        logic [SW-1:0] a, b;
        logic          c;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset.sum", {out_cout, out_sum}, 0);
        check_eq("reset.flags", {{(SW-3){1'b0}}, in_ready, out_valid, busy}, 4);

        run_op({SW{1'b1}}, 1, 1'b0, 0, 1'b0, "max_ovf");
        run_op({32'h0, {(SW-32){1'b1}}}, 0, 1'b1, 0, 1'b0, "carry_chain");
        run_op({WORDS{32'hFF32_0012}}, {WORDS{32'hBD30_2991}}, 1'b0, 1, 1'b0, "per_word");
        run_op({WORDS{32'hAAAA_AAAA}}, {WORDS{32'h5555_5555}}, 1'b1, 2, 1'b0, "alt_bits");
        run_op(rand_wide(), rand_wide(), 1'b1, 3, 1'b1, "backpressure");

        // Reset while idx==2 in RUN: the partial result must never appear.
        start_req({SW{1'b1}}, {SW{1'b1}}, 1'b1, "rst_mid");
        repeat (3) @(negedge clk);
        check_eq("rst_mid.busy", {{SW{1'b0}}, busy}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid.sum", {out_cout, out_sum}, 0);
        check_eq("rst_mid.flags", {{(SW-3){1'b0}}, in_ready, out_valid, busy}, 4);
        run_op(1, 2, 1'b0, 0, 1'b0, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            a = rand_wide();
            b = rand_wide();
            c = 1'($urandom_range(0, 1));
            run_op(a, b, c, $urandom_range(0, 3), ($urandom_range(0, 19) == 0),
                   $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
